fifo_push_arbiter: RTL and testbench
====================================

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameters SHALL be DATA_WIDTH = 32 (data bits), ADDR_WIDTH = 32 (address bits), MAX_BURST = 4 (maximum consecutive grants under lock, range 1..15).
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 rq0_req_i, rq1_req_i  in  1 each  OBI request from requester 0 and requester 1.
REQ-005 rq0_we_i, rq1_we_i  in  1 each  write enable (1 = push, 0 = read).
REQ-006 rq0_addr_i, rq1_addr_i  in  ADDR_WIDTH each  address, ignored.
REQ-007 rq0_be_i, rq1_be_i  in  4 each  byte enables, ignored.
REQ-008 rq0_wdata_i, rq1_wdata_i  in  DATA_WIDTH each  push data.
REQ-009 rq0_gnt_o, rq1_gnt_o  out  1 each  OBI grant.
REQ-010 rq0_rvalid_o, rq1_rvalid_o  out  1 each  OBI response valid.
REQ-011 rq0_rdata_o, rq1_rdata_o  out  DATA_WIDTH each  response data, constant 0.
REQ-012 fifo_full_i  in  1  downstream FIFO full flag.
REQ-013 fifo_push_o  out  1  push strobe to FIFO.
REQ-014 fifo_data_o  out  DATA_WIDTH  data to FIFO.

Function
REQ-015 Requester n SHALL be eligible when rqn_req_i = 1 and (rqn_we_i = 0 or fifo_full_i = 0).
REQ-016 At most one rqn_gnt_o SHALL be high per cycle; grant SHALL be combinational (same cycle as eligibility).
REQ-017 If only one requester is eligible, it SHALL be granted; if both, the requester named by the priority register prio (reset 0) SHALL be granted.
REQ-018 fifo_push_o SHALL equal the granted requester's we; fifo_data_o SHALL equal the granted requester's wdata, else 0.
REQ-019 A granted read (we = 0) SHALL not push and SHALL be answered normally.
REQ-020 rqn_rvalid_o SHALL be registered: high exactly one cycle after each rqn_gnt_o, low otherwise.
REQ-021 When fifo_full_i = 1 no write SHALL be granted; reads stay grantable; a stalled requester holds req/we/wdata stable until granted.
REQ-022 Without lock (REQ-027), after each grant to requester n, prio SHALL become 1-n (strict round robin).
REQ-023 A cycle with no grant SHALL leave prio and burst_cnt unchanged.
REQ-024 Simultaneous grant and fifo_full_i rising in the next cycle SHALL not cancel the registered rvalid of the granted transfer.
REQ-025 rdata outputs SHALL be constant 0 in all cycles.

Reset
REQ-026 On rst_ni = 0, asynchronously: prio = 0, burst_cnt = 0, both rvalid outputs = 0; gnt/push outputs then follow REQ-015..REQ-018 from inputs; reset mid-transfer SHALL drop any pending rvalid.

Configuration
REQ-027 Macro FIFO_PUSH_ARB_LOCK_EN SHALL select burst lock; when defined, a 4-bit burst_cnt counts consecutive grants to the same requester.
REQ-028 With FIFO_PUSH_ARB_LOCK_EN: after a grant to n, if burst_cnt+1 < MAX_BURST then prio = n and burst_cnt increments, else prio = 1-n and burst_cnt = 0; a grant to a requester different from the previous one SHALL restart burst_cnt at 1.
REQ-029 With FIFO_PUSH_ARB_LOCK_EN, if the locked requester drops req while the other is eligible, the other SHALL be granted that cycle and burst_cnt restarts.
REQ-030 Without FIFO_PUSH_ARB_LOCK_EN, burst_cnt SHALL not exist and REQ-022 applies.

Verification
REQ-031 After reset, rq0 writes 0xA5 alone, fifo_full_i=0 -> rq0_gnt_o=1, fifo_push_o=1, fifo_data_o=0xA5 same cycle; rq0_rvalid_o=1 next cycle only.
REQ-032 Both write continuously for 6 cycles, no lock -> grants alternate 0,1,0,1,0,1; 6 pushes.
REQ-033 Both write continuously, LOCK_EN, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1; rvalid trails each grant by 1 cycle.
REQ-034 fifo_full_i=1, rq0 writes, rq1 reads -> rq1 granted, fifo_push_o=0, rq1_rvalid_o next cycle with rdata 0; rq0 granted first cycle after fifo_full_i=0.
REQ-035 rst_ni asserted the cycle after a grant -> rvalid stays 0, prio=0; next dual request grants rq0.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// Two-requester OBI arbiter that funnels write transactions into a downstream FIFO push port.
// Optional burst lock is enabled by defining FIFO_PUSH_ARB_LOCK_EN.
module fifo_push_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rq0_req_i,
    input  logic                  rq1_req_i,
    input  logic                  rq0_we_i,
    input  logic                  rq1_we_i,
    input  logic [ADDR_WIDTH-1:0] rq0_addr_i,
    input  logic [ADDR_WIDTH-1:0] rq1_addr_i,
    input  logic [3:0]            rq0_be_i,
    input  logic [3:0]            rq1_be_i,
    input  logic [DATA_WIDTH-1:0] rq0_wdata_i,
    input  logic [DATA_WIDTH-1:0] rq1_wdata_i,
    output logic                  rq0_gnt_o,
    output logic                  rq1_gnt_o,
    output logic                  rq0_rvalid_o,
    output logic                  rq1_rvalid_o,
    output logic [DATA_WIDTH-1:0] rq0_rdata_o,
    output logic [DATA_WIDTH-1:0] rq1_rdata_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_push_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o
);

    // Handshake: a request is accepted in the cycle where req and gnt are both high;
    // the matching rvalid follows exactly one cycle later, with no backpressure on the response.

    logic prio;
    logic elig0;
    logic elig1;
    logic any_gnt;
    logic gnt_id;

    // Address and byte enables carry no meaning for a push port.
    logic unused_inputs;
    assign unused_inputs = ^{rq0_addr_i, rq1_addr_i, rq0_be_i, rq1_be_i};

    // A write is only eligible while the FIFO can take it; reads are always eligible.
    assign elig0 = rq0_req_i & (~rq0_we_i | ~fifo_full_i);
    assign elig1 = rq1_req_i & (~rq1_we_i | ~fifo_full_i);

    always_comb begin
        rq0_gnt_o = 1'b0;
        rq1_gnt_o = 1'b0;
        if (elig0 && elig1) begin
            rq0_gnt_o = ~prio;
            rq1_gnt_o = prio;
        end else begin
            rq0_gnt_o = elig0;
            rq1_gnt_o = elig1;
        end
    end

    assign any_gnt = rq0_gnt_o | rq1_gnt_o;
    assign gnt_id  = rq1_gnt_o;

    always_comb begin
        fifo_push_o = 1'b0;
        fifo_data_o = '0;
        if (rq0_gnt_o) begin
            fifo_push_o = rq0_we_i;
            fifo_data_o = rq0_wdata_i;
        end else if (rq1_gnt_o) begin
            fifo_push_o = rq1_we_i;
            fifo_data_o = rq1_wdata_i;
        end
    end

    assign rq0_rdata_o = '0;
    assign rq1_rdata_o = '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rq0_rvalid_o <= 1'b0;
            rq1_rvalid_o <= 1'b0;
        end else begin
            rq0_rvalid_o <= rq0_gnt_o;
            rq1_rvalid_o <= rq1_gnt_o;
        end
    end

`ifdef FIFO_PUSH_ARB_LOCK_EN
    localparam logic [3:0] MAX_BURST_W = 4'(MAX_BURST);

    logic [3:0] burst_cnt;
    logic       last_id;
    logic [3:0] run_len;

    // burst_cnt == 0 means no burst is open, so the next grant starts a fresh run.
    assign run_len = (burst_cnt != 4'd0 && last_id == gnt_id) ? burst_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio      <= 1'b0;
            burst_cnt <= 4'd0;
            last_id   <= 1'b0;
        end else if (any_gnt) begin
            last_id <= gnt_id;
            if (run_len < MAX_BURST_W) begin
                prio      <= gnt_id;
                burst_cnt <= run_len;
            end else begin
                prio      <= ~gnt_id;
                burst_cnt <= 4'd0;
            end
        end
    end
`else
    localparam int UNUSED_MAX_BURST = MAX_BURST;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio <= 1'b0;
        end else if (any_gnt) begin
            prio <= ~gnt_id;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model and an expected-push queue.
module tb_fifo_push_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rq0_req, rq1_req, rq0_we, rq1_we;
    logic [AW-1:0] rq0_addr, rq1_addr;
    logic [3:0]    rq0_be, rq1_be;
    logic [DW-1:0] rq0_wdata, rq1_wdata;
    logic          rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid;
    logic [DW-1:0] rq0_rdata, rq1_rdata;
    logic          fifo_full, fifo_push;
    logic [DW-1:0] fifo_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_prio, m_streak, m_last;
    logic          m_rv0, m_rv1;
    logic          e_g0, e_g1, e_push;
    logic [DW-1:0] e_data;
    logic [DW-1:0] exp_q[$];

    fifo_push_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rq0_req_i(rq0_req), .rq1_req_i(rq1_req),
        .rq0_we_i(rq0_we), .rq1_we_i(rq1_we),
        .rq0_addr_i(rq0_addr), .rq1_addr_i(rq1_addr),
        .rq0_be_i(rq0_be), .rq1_be_i(rq1_be),
        .rq0_wdata_i(rq0_wdata), .rq1_wdata_i(rq1_wdata),
        .rq0_gnt_o(rq0_gnt), .rq1_gnt_o(rq1_gnt),
        .rq0_rvalid_o(rq0_rvalid), .rq1_rvalid_o(rq1_rvalid),
        .rq0_rdata_o(rq0_rdata), .rq1_rdata_o(rq1_rdata),
        .fifo_full_i(fifo_full), .fifo_push_o(fifo_push), .fifo_data_o(fifo_data)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic model_reset();
        m_prio = 0; m_streak = 0; m_last = 0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    endtask

    // Who should win this cycle, from the eligibility and priority rules.
    task automatic model_eval();
        logic el0, el1;
        el0 = rq0_req && (!rq0_we || !fifo_full);
        el1 = rq1_req && (!rq1_we || !fifo_full);
        e_g0 = 1'b0; e_g1 = 1'b0;
        if (el0 && el1) begin
            if (m_prio == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
        end else begin
            e_g0 = el0; e_g1 = el1;
        end
        e_push = e_g0 ? rq0_we : (e_g1 ? rq1_we : 1'b0);
        e_data = e_g0 ? rq0_wdata : (e_g1 ? rq1_wdata : '0);
    endtask

    // Advance the model across one rising edge.
    task automatic model_commit();
        int n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_rv0 = e_g0; m_rv1 = e_g1;
        if (e_g0 || e_g1) begin
            n = e_g1 ? 1 : 0;
`ifdef FIFO_PUSH_ARB_LOCK_EN
            if (n == m_last && m_streak > 0) m_streak++; else m_streak = 1;
            m_last = n;
            if (m_streak >= MB) begin
                m_prio = 1 - n; m_streak = 0;
            end else begin
                m_prio = n;
            end
`else
            m_prio = 1 - n;
`endif
        end
    endtask

    // Driver tasks
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rq0_req = 1'b0; rq1_req = 1'b0; rq0_we = 1'b0; rq1_we = 1'b0;
        rq0_addr = '0; rq1_addr = '0; rq0_be = '0; rq1_be = '0;
        rq0_wdata = '0; rq1_wdata = '0; fifo_full = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        checks++; if (rq0_rvalid !== 1'b0 || rq1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b want 00", rq0_rvalid, rq1_rvalid); end
        checks++; if ({rq0_gnt, rq1_gnt, fifo_push} !== 3'b000) begin errors++; $display("FAIL reset_idle_gnt got %b want 000", {rq0_gnt, rq1_gnt, fifo_push}); end
        checks++; if (fifo_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", fifo_data); end
        tick();
    endtask

    task automatic test_single_write();
        apply_reset();
        rq0_req = 1'b1; rq0_we = 1'b1; rq0_wdata = 32'hA5;
        settle();
        checks++; if ({rq0_gnt, rq1_gnt} !== 2'b10) begin errors++; $display("FAIL single_gnt got %b want 10", {rq0_gnt, rq1_gnt}); end
        checks++; if (fifo_push !== 1'b1) begin errors++; $display("FAIL single_push got %b want 1", fifo_push); end
        checks++; if (fifo_data !== 32'hA5) begin errors++; $display("FAIL single_data got %h want a5", fifo_data); end
        checks++; if (rq0_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_early got %b want 0", rq0_rvalid); end
        tick();
        // FIFO fills right after the grant: the accepted write must still be answered.
        rq0_wdata = 32'h5A; fifo_full = 1'b1;
        settle();
        checks++; if (rq0_gnt !== 1'b0 || fifo_push !== 1'b0) begin errors++; $display("FAIL full_blocks_write got gnt=%b push=%b want 0 0", rq0_gnt, fifo_push); end
        checks++; if (rq0_rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got %b want 1", rq0_rvalid); end
        tick();
        settle();
        checks++; if (rq0_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_once got %b want 0", rq0_rvalid); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int n_cyc, pushes, exp_id, prev_id;
        apply_reset();
`ifdef FIFO_PUSH_ARB_LOCK_EN
        n_cyc = 2 * MB;
`else
        n_cyc = 6;
`endif
        pushes = 0; prev_id = -1;
        rq0_req = 1'b1; rq0_we = 1'b1; rq0_wdata = 32'h1111_0000;
        rq1_req = 1'b1; rq1_we = 1'b1; rq1_wdata = 32'h2222_0000;
        for (int i = 0; i < n_cyc; i++) begin
            settle();
`ifdef FIFO_PUSH_ARB_LOCK_EN
            exp_id = (i / MB) % 2;
`else
            exp_id = i % 2;
`endif
            checks++; if (rq0_gnt !== (exp_id == 0) || rq1_gnt !== (exp_id == 1)) begin errors++; $display("FAIL b2b_gnt cycle %0d got %b%b want rq%0d", i, rq0_gnt, rq1_gnt, exp_id); end
            checks++; if (fifo_data !== (exp_id == 0 ? 32'h1111_0000 : 32'h2222_0000)) begin errors++; $display("FAIL b2b_data cycle %0d got %h", i, fifo_data); end
            if (prev_id >= 0) begin
                checks++; if (rq0_rvalid !== (prev_id == 0) || rq1_rvalid !== (prev_id == 1)) begin errors++; $display("FAIL b2b_rvalid cycle %0d got %b%b want rq%0d", i, rq0_rvalid, rq1_rvalid, prev_id); end
            end
            if (fifo_push === 1'b1) pushes++;
            prev_id = exp_id;
            tick();
        end
        idle_inputs();
        settle();
        checks++; if (rq0_rvalid !== (prev_id == 0) || rq1_rvalid !== (prev_id == 1)) begin errors++; $display("FAIL b2b_last_rvalid got %b%b want rq%0d", rq0_rvalid, rq1_rvalid, prev_id); end
        checks++; if (pushes !== n_cyc) begin errors++; $display("FAIL b2b_push_count got %0d want %0d", pushes, n_cyc); end
        tick();
    endtask

    task automatic test_full_read();
        apply_reset();
        fifo_full = 1'b1;
        rq0_req = 1'b1; rq0_we = 1'b1; rq0_wdata = 32'hCAFE_0001;
        rq1_req = 1'b1; rq1_we = 1'b0; rq1_wdata = 32'h0000_0077;
        settle();
        checks++; if ({rq0_gnt, rq1_gnt} !== 2'b01) begin errors++; $display("FAIL full_read_gnt got %b want 01", {rq0_gnt, rq1_gnt}); end
        checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL full_read_push got %b want 0", fifo_push); end
        tick();
        rq1_req = 1'b0;
        settle();
        checks++; if (rq1_rvalid !== 1'b1 || rq1_rdata !== '0) begin errors++; $display("FAIL full_read_resp got rv=%b rdata=%h want 1 0", rq1_rvalid, rq1_rdata); end
        checks++; if (rq0_gnt !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", rq0_gnt); end
        tick();
        fifo_full = 1'b0;
        settle();
        checks++; if (rq0_gnt !== 1'b1 || fifo_push !== 1'b1 || fifo_data !== 32'hCAFE_0001) begin errors++; $display("FAIL full_release got gnt=%b push=%b data=%h want 1 1 cafe0001", rq0_gnt, fifo_push, fifo_data); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        // Leave priority pointing at rq1 before the reset hits.
`ifdef FIFO_PUSH_ARB_LOCK_EN
        rq1_req = 1'b1; rq1_we = 1'b1; rq1_wdata = 32'h33;
`else
        rq0_req = 1'b1; rq0_we = 1'b1; rq0_wdata = 32'h33;
`endif
        settle();
        tick();
        rst_n = 1'b0;
        model_reset();
        idle_inputs();
        settle();
        checks++; if (rq0_rvalid !== 1'b0 || rq1_rvalid !== 1'b0) begin errors++; $display("FAIL midreset_rvalid got %b%b want 00", rq0_rvalid, rq1_rvalid); end
        tick();
        rst_n = 1'b1;
        rq0_req = 1'b1; rq0_we = 1'b1; rq1_req = 1'b1; rq1_we = 1'b1;
        settle();
        checks++; if ({rq0_gnt, rq1_gnt} !== 2'b10) begin errors++; $display("FAIL midreset_prio got %b want 10", {rq0_gnt, rq1_gnt}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] got;
        apply_reset();
        exp_q.delete();
        e_g0 = 1'b0; e_g1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!rst_n) model_reset();
            if (!(rq0_req && !e_g0) || !rst_n) begin
                rq0_req = ($urandom_range(0, 3) != 0); rq0_we = ($urandom_range(0, 2) != 0);
                rq0_wdata = $urandom; rq0_addr = $urandom; rq0_be = 4'($urandom);
            end
            if (!(rq1_req && !e_g1) || !rst_n) begin
                rq1_req = ($urandom_range(0, 3) != 0); rq1_we = ($urandom_range(0, 2) != 0);
                rq1_wdata = $urandom; rq1_addr = $urandom; rq1_be = 4'($urandom);
            end
            fifo_full = ($urandom_range(0, 2) == 0);
            settle();
            checks++; if (rq0_gnt !== e_g0 || rq1_gnt !== e_g1) begin errors++; $display("FAIL rand_gnt cycle %0d got %b%b want %b%b", i, rq0_gnt, rq1_gnt, e_g0, e_g1); end
            checks++; if (fifo_push !== e_push || fifo_data !== e_data) begin errors++; $display("FAIL rand_push cycle %0d got %b/%h want %b/%h", i, fifo_push, fifo_data, e_push, e_data); end
            checks++; if (rq0_rvalid !== m_rv0 || rq1_rvalid !== m_rv1) begin errors++; $display("FAIL rand_rvalid cycle %0d got %b%b want %b%b", i, rq0_rvalid, rq1_rvalid, m_rv0, m_rv1); end
            checks++; if (rq0_rdata !== '0 || rq1_rdata !== '0) begin errors++; $display("FAIL rand_rdata cycle %0d got %h %h want 0", i, rq0_rdata, rq1_rdata); end
            if (e_push) exp_q.push_back(e_data);
            if (fifo_push === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_sb_unexpected cycle %0d got %h want none", i, fifo_data);
                end else begin
                    got = exp_q.pop_front();
                    if (fifo_data !== got) begin errors++; $display("FAIL rand_sb_data cycle %0d got %h want %h", i, fifo_data, got); end
                end
            end
            tick();
        end
        rst_n = 1'b1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_sb_left got %0d want 0", exp_q.size()); end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_full_read();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
